// File: rtl/risc_mgmt_pkg.sv
// Shared types for the RISC-MGMT dispatch controller: FSM states, the extension
// count limit and the owner index type.
package risc_mgmt_pkg;

  localparam int MAX_EXT = 16;
  localparam int OWNER_W = $clog2(MAX_EXT);

  typedef logic [OWNER_W-1:0] owner_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MEM,
    DONE
  } dispatch_state_t;

endpackage

// File: rtl/rmgmt_prio_enc.sv
// Lowest-index-wins priority encoder: returns the winning index, its one-hot
// form and whether any request bit was set.
module rmgmt_prio_enc
  import risc_mgmt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output owner_idx_t   idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  // NOTE: every output gets a default before the loop, otherwise the
  // combinational block would infer latches on the no-request path.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |req;
    // Walk downwards so the lowest set bit is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = owner_idx_t'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risc_mgmt_dispatch.sv
// Dispatch controller between the execute stage and NUM_EXT custom-instruction
// extensions: claims ownership, sequences EXEC/MEM/DONE and reports exceptions.
module risc_mgmt_dispatch
  import risc_mgmt_pkg::*;
#(
  parameter int NUM_EXT     = 4,
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    insn_valid,
  input  logic                    if_ex_enable,
  input  logic [NUM_EXT-1:0]      ext_claim,
  input  logic [NUM_EXT-1:0]      ext_done,
  input  logic [NUM_EXT-1:0]      ext_exception,
  input  logic [NUM_EXT-1:0]      ext_req_mem,
  input  logic [NUM_EXT-1:0]      ext_mem_wen,
  input  logic [NUM_EXT*WORD_W-1:0] ext_mem_addr,
  input  logic [NUM_EXT*WORD_W-1:0] ext_mem_store,
  input  logic [NUM_EXT*WORD_W-1:0] ext_reg_wdata,
  input  logic [NUM_EXT*5-1:0]    ext_rsel_d,
  input  logic                    mem_busy,
  input  logic [WORD_W-1:0]       mem_load,
  output logic [NUM_EXT-1:0]      ext_start,
  output logic                    active_insn,
  output logic                    execute_stall,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [WORD_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_store,
  output logic [WORD_W-1:0]       ext_mem_load,
  output logic                    reg_w,
  output logic [WORD_W-1:0]       reg_wdata,
  output logic [4:0]              rsel_d,
  output logic                    exception,
  output logic [NUM_EXT-1:0]      ex_cause,
  output logic                    timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  dispatch_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_idx_t       owner_q, owner_d;
  logic [WORD_W-1:0] wdata_q, addr_q, store_q;
  logic [4:0]        rsel_q;
  logic              wen_q;
  logic              wb_ld, mem_ld, load_ld;

  owner_idx_t         claim_idx;
  logic [NUM_EXT-1:0] claim_oh;
  logic               claim_any;

  rmgmt_prio_enc #(.N(NUM_EXT)) u_prio_enc (
    .req    (ext_claim),
    .idx    (claim_idx),
    .onehot (claim_oh),
    .any    (claim_any)
  );

  // Owner's view of the extension bus; an unused owner_q value selects nothing.
  logic               own_done, own_exc, own_req, own_wen;
  logic [WORD_W-1:0]  own_addr, own_store, own_wdata;
  logic [4:0]         own_rsel;
  logic [NUM_EXT-1:0] owner_oh;

  always_comb begin
    own_done  = 1'b0;
    own_exc   = 1'b0;
    own_req   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_store = '0;
    own_wdata = '0;
    own_rsel  = '0;
    owner_oh  = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (owner_q == owner_idx_t'(i)) begin
        own_done    = ext_done[i];
        own_exc     = ext_exception[i];
        own_req     = ext_req_mem[i];
        own_wen     = ext_mem_wen[i];
        own_addr    = ext_mem_addr[i*WORD_W +: WORD_W];
        own_store   = ext_mem_store[i*WORD_W +: WORD_W];
        own_wdata   = ext_reg_wdata[i*WORD_W +: WORD_W];
        own_rsel    = ext_rsel_d[i*5 +: 5];
        owner_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    wb_ld         = 1'b0;
    mem_ld        = 1'b0;
    load_ld       = 1'b0;
    ext_start     = '0;
    active_insn   = 1'b0;
    execute_stall = 1'b0;
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_store     = '0;
    reg_w         = 1'b0;
    reg_wdata     = '0;
    rsel_d        = '0;
    exception     = 1'b0;
    ex_cause      = '0;
    timeout       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The start pulse is combinational from the decode hit, so hold it
        // off while reset is asserted to keep every output quiet.
        if (insn_valid && claim_any && !RST) begin
          ext_start     = claim_oh;
          execute_stall = 1'b1;
          owner_d       = claim_idx;
          cnt_d         = '0;
          state_d       = EXEC;
        end
      end

      EXEC: begin
        active_insn = 1'b1;
        if (own_exc) begin
          exception = 1'b1;
          ex_cause  = owner_oh;
          state_d   = IDLE;
        end else if (own_done) begin
          execute_stall = 1'b1;
          wb_ld         = 1'b1;
          state_d       = DONE;
        end else if (own_req) begin
          execute_stall = 1'b1;
          mem_ld        = 1'b1;
          state_d       = MEM;
        end else if (cnt_q == CNT_LAST) begin
          exception = 1'b1;
          timeout   = 1'b1;
          ex_cause  = owner_oh;
          state_d   = IDLE;
        end else begin
          execute_stall = 1'b1;
          cnt_d         = cnt_q + 1'b1;
        end
      end

      MEM: begin
        active_insn   = 1'b1;
        execute_stall = 1'b1;
        mem_ren       = !wen_q;
        mem_wen       = wen_q;
        mem_addr      = addr_q;
        mem_store     = store_q;
        if (!mem_busy) begin
          load_ld = 1'b1;
          state_d = EXEC;
        end
      end

      DONE: begin
        active_insn = 1'b1;
        reg_w       = 1'b1;
        reg_wdata   = wdata_q;
        rsel_d      = rsel_q;
        if (if_ex_enable) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= '0;
      wdata_q      <= '0;
      rsel_q       <= '0;
      addr_q       <= '0;
      store_q      <= '0;
      wen_q        <= 1'b0;
      ext_mem_load <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      if (wb_ld) begin
        wdata_q <= own_wdata;
        rsel_q  <= own_rsel;
      end
      if (mem_ld) begin
        addr_q  <= own_addr;
        store_q <= own_store;
        wen_q   <= own_wen;
      end
      if (load_ld) ext_mem_load <= mem_load;
    end
  end

endmodule
